sobel_rgb_join: RTL and testbench
=================================

Name: sobel_rgb_join

Overview:
- Downstream stage of the three per-channel Sobel filters; consumes their three 8-bit valid/ready/last streams and joins them into one 24-bit RGB stream with a frame-end marker.
- Feeds the AXI-Stream output wrapper.
- Aligns the channels by lock-step handshake.
- Decouples the output ready path through a 2-entry skid buffer.

Parameters:
- WIDTH_P, 10, image width in pixels (frame-check beat count).
- HEIGHT_P, 10, image height in pixels (frame-check beat count).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- valid_i  in  3  per-channel valid; bit k = channel k
- ready_o  out  3  per-channel ready
- pixel_i  in  24  channel k pixel at bits [8k+7:8k]
- last_i  in  3  per-channel last-pixel flag
- valid_o  out  1  joined pixel valid
- ready_i  in  1  downstream ready
- pixel_o  out  24  joined pixel, same byte packing as pixel_i
- last_o  out  1  last pixel of frame
- err_o  out  2  sticky frame errors: bit0 = channel last mismatch; bit1 = last at wrong beat count

Behaviour:
- Reset: skid buffer empty; valid_o=0, last_o=0, pixel_o=0, err_o=0, beat counter=0.
- Join rule:
  - all_v = &valid_i.
  - space = (count_r < 2).
  - ready_o = {3{all_v & space}].
  - All three channels are accepted in the same cycle or none is; a channel never sees ready without the other two being valid.
  - ready_o never depends combinationally on ready_i.
- Push: all_v & space. Entry stored = {pixel_i, last_i[0]}.
- Pop: valid_o & ready_i.
- valid_o = (count_r != 0); pixel_o/last_o come from the head entry, which is registered.
- Latency: an accepted triple appears on the outputs the next cycle.
- Throughput:
  - 1 pixel/cycle at count_r=1 with simultaneous push and pop; count unchanged.
  - Push at count_r=2 is blocked.
  - Pop at count_r=0 is impossible.
- Ordering: FIFO order, 2 entries, pointer wrap mod 2.
- Output is held stable while valid_o & ~ready_i: pixel_o and last_o must not change.
- Reset mid-frame discards buffered entries and counters; the next accepted triple starts a new frame.
- Values are passed unmodified; no arithmetic on pixel data.

Optional Feature:
- Macro SOBEL_JOIN_FRAME_CHECK_EN.
- When defined:
  - Beat counter (width $clog2(WIDTH_P*HEIGHT_P+1)) increments on each push.
  - On a push with last_i not all-equal (not 000/111), set err_o[0].
  - On a push with last_i[0]=1 and counter != WIDTH_P*HEIGHT_P-1, set err_o[1].
  - On a push with last_i[0]=0 and counter == WIDTH_P*HEIGHT_P-1, set err_o[1].
  - Counter clears on a push with last_i[0]=1.
  - err_o bits are sticky until reset_i.
- When undefined:
  - No counter logic.
  - err_o tied to 2'b00.
  - Datapath and handshake are identical.

Decomposition:
- Shared package sobel_pkg holds:
  - localparam CHANNELS_P=3
  - typedef rgb_pixel_t (packed 3x8-bit)
  - constants ERR_LAST_MISMATCH_C=0, ERR_LAST_COUNT_C=1
- One sub-module: sobel_skid_fifo, a 2-entry valid/ready register FIFO parameterised on data width, with count output. It is instantiated once with width 25.

Test Plan:
- Streaming: all valid_i=111, ready_i=1, pixel_i=0x112233 then 0x445566 -> after 1 cycle, pixel_o=0x112233 then 0x445566 on consecutive cycles; ready_o=111 throughout.
- Skew: valid_i=011 for 3 cycles, then 111 -> ready_o=000 for the 3 cycles; a single push on the 111 cycle; valid_o=1 the next cycle.
- Backpressure: ready_i=0, push 3 triples -> the third triple waits (ready_o=000 once count=2); pixel_o is held at the first value. ready_i=1 -> outputs 1st, 2nd, 3rd in order, no loss or duplication.
- Frame end (WIDTH_P=HEIGHT_P=10): 100 triples with last_i=111 on beat 100 -> last_o=1 only on the 100th output; err_o=00. The next frame counts from 0.
- Frame errors (macro defined):
  - last_i=101 on beat 5 -> err_o[0]=1, sticky.
  - A new reset, then last_i=111 on beat 50 -> err_o[1]=1.
  - With the macro undefined, the same stimulus leaves err_o=00.
- Reset mid-frame: reset_i=1 while count=2 and valid_o=1 -> next cycle valid_o=0, err_o=0; a fresh 100-beat frame completes with no errors.

Source files
------------

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types and constants for the Sobel RGB join stage
package sobel_pkg;

    localparam int CHANNELS_P = 3;

    typedef logic [CHANNELS_P-1:0][7:0] rgb_pixel_t;

    localparam int ERR_LAST_MISMATCH_C = 0;
    localparam int ERR_LAST_COUNT_C    = 1;

endpackage

// File: rtl/sobel_skid_fifo.sv
// rtl/sobel_skid_fifo.sv - 2-entry register FIFO with valid/ready style push/pop and count
module sobel_skid_fifo #(
    parameter int WIDTH_P = 25
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [WIDTH_P-1:0] din,
    input  logic               pop,
    output logic [WIDTH_P-1:0] dout,
    output logic [1:0]         count
);

    logic [WIDTH_P-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head slot is never written while occupied, so dout holds under backpressure.
    assign dout = mem[rd_ptr];

endmodule

// File: rtl/sobel_rgb_join.sv
// rtl/sobel_rgb_join.sv - joins three 8-bit Sobel channel streams into one 24-bit RGB stream; frame check under SOBEL_JOIN_FRAME_CHECK_EN
module sobel_rgb_join
    import sobel_pkg::*;
#(
    parameter int WIDTH_P  = 10,
    parameter int HEIGHT_P = 10
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [CHANNELS_P-1:0] valid_i,
    output logic [CHANNELS_P-1:0] ready_o,
    input  logic [23:0]           pixel_i,
    input  logic [CHANNELS_P-1:0] last_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [23:0]           pixel_o,
    output logic                  last_o,
    output logic [1:0]            err_o
);

    localparam int FRAME_BEATS = WIDTH_P * HEIGHT_P;

    logic        all_v;
    logic        space;
    logic        push;
    logic        pop;
    logic [1:0]  count_r;
    logic [24:0] head;

    assign all_v   = &valid_i;
    assign space   = (count_r < 2'd2);
    assign push    = all_v && space;
    assign ready_o = {CHANNELS_P{push}};
    assign pop     = valid_o && ready_i;
    assign valid_o = (count_r != 2'd0);

    sobel_skid_fifo #(
        .WIDTH_P(25)
    ) u_skid (
        .clk   (clk_i),
        .reset (reset_i),
        .push  (push),
        .din   ({rgb_pixel_t'(pixel_i), last_i[0]}),
        .pop   (pop),
        .dout  (head),
        .count (count_r)
    );

    assign pixel_o = head[24:1];
    assign last_o  = head[0];

`ifdef SOBEL_JOIN_FRAME_CHECK_EN
    localparam int CNT_W = $clog2(FRAME_BEATS + 1);

    logic [CNT_W-1:0] beat_r;
    logic [1:0]       err_r;
    logic             at_end;

    assign at_end = (beat_r == CNT_W'(FRAME_BEATS - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            beat_r <= '0;
            err_r  <= 2'b00;
        end else if (push) begin
            if ((last_i != 3'b000) && (last_i != 3'b111)) begin
                err_r[ERR_LAST_MISMATCH_C] <= 1'b1;
            end
            if (last_i[0] != at_end) begin
                err_r[ERR_LAST_COUNT_C] <= 1'b1;
            end
            beat_r <= last_i[0] ? '0 : beat_r + 1'b1;
        end
    end

    assign err_o = err_r;
`else
    logic unused_frame_cfg;

    // Channel last flags beyond channel 0 only feed the frame check.
    assign unused_frame_cfg = ^{last_i[2:1], (FRAME_BEATS > 0)};
    assign err_o = 2'b00;
`endif

endmodule

// File: tb/tb_sobel_rgb_join.sv
// tb/tb_sobel_rgb_join.sv - randomized self-checking bench for sobel_rgb_join against a queue model
module tb_sobel_rgb_join;

    localparam int W     = 10;
    localparam int H     = 10;
    localparam int FRAME = W * H;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [2:0]  valid_i;
    logic [2:0]  ready_o;
    logic [23:0] pixel_i;
    logic [2:0]  last_i;
    logic        valid_o;
    logic        ready_i;
    logic [23:0] pixel_o;
    logic        last_o;
    logic [1:0]  err_o;

    int checks = 0;
    int errors = 0;

    logic [24:0] q[$];
    int          m_beat;
    logic [1:0]  m_err;
    logic        m_push;

    always #5 clk_i = ~clk_i;

    sobel_rgb_join #(.WIDTH_P(W), .HEIGHT_P(H)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .pixel_i (pixel_i),
        .last_i  (last_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .pixel_o (pixel_o),
        .last_o  (last_o),
        .err_o   (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_err();
`ifdef SOBEL_JOIN_FRAME_CHECK_EN
        return m_err;
`else
        return 2'b00;
`endif
    endfunction

    // One clock: drive, check outputs mid-cycle against the model, then advance the model.
    task automatic step(input logic [2:0] v, input logic [23:0] px, input logic [2:0] lst, input logic rdy);
        logic pop;
        valid_i = v;
        pixel_i = px;
        last_i  = lst;
        ready_i = rdy;
        m_push  = (v == 3'b111) && (q.size() < 2);
        pop     = (q.size() != 0) && rdy;
        @(negedge clk_i);
        chk("ready_o", ready_o, {3{m_push}});
        chk("valid_o", valid_o, q.size() != 0);
        chk("err_o", err_o, exp_err());
        if (q.size() != 0) begin
            chk("pixel_o", pixel_o, q[0][24:1]);
            chk("last_o", last_o, q[0][0]);
        end
        @(posedge clk_i);
        if (pop) void'(q.pop_front());
        if (m_push) begin
            q.push_back({px, lst[0]});
            if (lst != 3'b000 && lst != 3'b111) m_err[0] = 1'b1;
            // Last must arrive exactly on the final pixel of the frame.
            if (lst[0] != (m_beat + 1 == FRAME)) m_err[1] = 1'b1;
            m_beat = lst[0] ? 0 : m_beat + 1;
        end
        #1;
    endtask

    task automatic send(input logic [23:0] px, input logic [2:0] lst, input bit rand_rdy);
        int tries = 0;
        m_push = 1'b0;
        while (!m_push && tries < 20) begin
            step(3'b111, px, lst, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            tries++;
        end
        if (!m_push) chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        int tries = 0;
        while (q.size() != 0 && tries < 20) begin
            step(3'b000, 24'($urandom), 3'b000, 1'b1);
            tries++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        valid_i = 3'b000;
        ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        q.delete();
        m_beat = 0;
        m_err  = 2'b00;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_last_o", last_o, 0);
        chk("rst_pixel_o", pixel_o, 0);
        chk("rst_err_o", err_o, 0);
        chk("rst_ready_o", ready_o, 0);
    endtask

    task automatic frame(input int n, input logic [2:0] last_end, input bit rand_rdy);
        for (int i = 1; i <= n; i++) begin
            send(24'($urandom), (i == n) ? last_end : 3'b000, rand_rdy);
            if ($urandom_range(0, 3) == 0) step(3'($urandom_range(0, 6)), 24'($urandom), 3'b000, 1'b1);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        valid_i = 3'b000;
        pixel_i = '0;
        last_i  = 3'b000;
        ready_i = 1'b0;
        m_beat  = 0;
        m_err   = 2'b00;
        m_push  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        do_reset();

        // Streaming two known pixels, then random pixels at full rate
        step(3'b111, 24'h112233, 3'b000, 1'b1);
        step(3'b111, 24'h445566, 3'b000, 1'b1);
        for (int i = 0; i < 10; i++) step(3'b111, 24'($urandom), 3'b000, 1'b1);
        drain();

        // Channel skew: partial valid never gets ready
        for (int i = 0; i < 3; i++) step(3'b011, 24'hABCDEF, 3'b000, 1'b1);
        step(3'b111, 24'hABCDEF, 3'b000, 1'b1);
        chk("skew_pushed", m_push, 1);
        drain();

        // Backpressure: third triple waits until the buffer drains
        step(3'b111, 24'h010101, 3'b000, 1'b0);
        step(3'b111, 24'h020202, 3'b000, 1'b0);
        step(3'b111, 24'h030303, 3'b000, 1'b0);
        chk("bp_blocked", m_push, 0);
        step(3'b111, 24'h030303, 3'b000, 1'b0);
        send(24'h030303, 3'b000, 1'b0);
        drain();

        // Random valid/ready traffic
        for (int i = 0; i < 150; i++) begin
            step(($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111, 24'($urandom), 3'b000,
                 1'($urandom_range(0, 1)));
        end
        drain();

        // Two clean frames back to back
        do_reset();
        frame(FRAME, 3'b111, 1'b1);
        frame(FRAME, 3'b111, 1'b1);
        drain();
        chk("frames_err", err_o, 0);

        // Mismatched channel last flags on beat 5
        do_reset();
        frame(5, 3'b101, 1'b0);
        frame(3, 3'b000, 1'b0);
        drain();
`ifdef SOBEL_JOIN_FRAME_CHECK_EN
        chk("err0_sticky", err_o[0], 1);
`else
        chk("err0_sticky", err_o[0], 0);
`endif

        // Early frame end on beat 50
        do_reset();
        frame(50, 3'b111, 1'b0);
        drain();
`ifdef SOBEL_JOIN_FRAME_CHECK_EN
        chk("err1_early", err_o, 2'b10);
`else
        chk("err1_early", err_o, 2'b00);
`endif

        // Reset with a full buffer mid-frame, then a fresh frame
        do_reset();
        frame(30, 3'b000, 1'b1);
        step(3'b111, 24'h0A0B0C, 3'b000, 1'b0);
        step(3'b111, 24'h0D0E0F, 3'b000, 1'b0);
        step(3'b111, 24'h101112, 3'b000, 1'b0);
        chk("full_before_reset", q.size(), 2);
        do_reset();
        frame(FRAME, 3'b111, 1'b0);
        drain();
        chk("post_reset_frame_err", err_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
